// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader for the 2-bit CPU core.
// Shifts in INSTR_W-bit words MSB first and writes them to instruction memory
// addresses 0..DEPTH-1. The core is held in reset until a complete program is
// resident.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When it is defined, a
// trailing INSTR_W-bit XOR checksum is checked after the last word.
module prog_loader #(
  parameter int INSTR_W = 2,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               ser_valid,
  input  logic               ser_bit,
  output logic               ser_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_err
);

  localparam int CNT_W = (INSTR_W > 1) ? $clog2(INSTR_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(INSTR_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    ST_CHECK = 3'd4,
    ST_ERROR = 3'd5
`endif
  } state_t;

  state_t              state_r, state_s;
  logic [INSTR_W-1:0]  shift_r, shift_s;
  logic [INSTR_W-1:0]  shifted_s;
  logic [CNT_W-1:0]    bitcnt_r, bitcnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [INSTR_W-1:0]  wdata_r, wdata_s;
  logic                accept_s;
  logic                ser_ready_r, imem_we_r, cpu_reset_r, load_done_r;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0]  csum_r, csum_s;
  logic                load_err_r;

  // Running checksum: each written word folds in by XOR.
  function automatic logic [INSTR_W-1:0] csum_fold(input logic [INSTR_W-1:0] acc,
                                                    input logic [INSTR_W-1:0] word);
    csum_fold = acc ^ word;
  endfunction
`endif

  // A bit moves only when the loader advertised ready on this edge.
  assign accept_s  = ser_valid & ser_ready_r;
  assign shifted_s = {shift_r[INSTR_W-2:0], ser_bit};

  // Next-state and datapath decisions for the load sequence.
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    bitcnt_s = bitcnt_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_s   = csum_r;
`endif
    case (state_r)
      ST_IDLE,
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_ERROR,
`endif
      ST_DONE: begin
        if (start) begin
          state_s  = ST_SHIFT;
          addr_s   = '0;
          bitcnt_s = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_s   = '0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          shift_s = shifted_s;
          if (bitcnt_r == LAST_BIT) begin
            bitcnt_s = '0;
            wdata_s  = shifted_s;
            state_s  = ST_WRITE;
          end else begin
            bitcnt_s = bitcnt_r + 1'b1;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_s = csum_fold(csum_r, wdata_r);
`endif
        // The address saturates at the last entry; completion replaces wrap.
        if (addr_r == LAST_ADDR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_s = ST_CHECK;
`else
          state_s = ST_DONE;
`endif
        end else begin
          addr_s  = addr_r + 1'b1;
          state_s = ST_SHIFT;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          shift_s = shifted_s;
          if (bitcnt_r == LAST_BIT) begin
            bitcnt_s = '0;
            state_s  = (shifted_s == csum_r) ? ST_DONE : ST_ERROR;
          end else begin
            bitcnt_s = bitcnt_r + 1'b1;
          end
        end else begin
          state_s = ST_CHECK;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      bitcnt_r <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_r   <= '0;
`endif
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      bitcnt_r <= bitcnt_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_r   <= csum_s;
`endif
    end
  end

  // Output flags are registered from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_ready_r <= 1'b0;
      imem_we_r   <= 1'b0;
      cpu_reset_r <= 1'b1;
      load_done_r <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      load_err_r  <= 1'b0;
`endif
    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
      ser_ready_r <= (state_s == ST_SHIFT) || (state_s == ST_CHECK);
      load_err_r  <= (state_s == ST_ERROR);
`else
      ser_ready_r <= (state_s == ST_SHIFT);
`endif
      imem_we_r   <= (state_s == ST_WRITE);
      cpu_reset_r <= (state_s != ST_DONE);
      load_done_r <= (state_s == ST_DONE);
    end
  end

  assign ser_ready  = ser_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign load_done  = load_done_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign load_err   = load_err_r;
`else
  assign load_err   = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader with a
// word/phase-level reference model and a per-cycle compare process.
module tb_prog_loader;
  localparam int INSTR_W = 2;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CSUM_BITS = INSTR_W;
  localparam bit CSUM_ON   = 1'b1;
`else
  localparam int CSUM_BITS = 0;
  localparam bit CSUM_ON   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, start, ser_valid, ser_bit;
  logic ser_ready, imem_we, cpu_reset, load_done, load_err;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  prog_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ser_valid(ser_valid),
    .ser_bit(ser_bit), .ser_ready(ser_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = 0;
  logic prev_cr = 1'b1;

  // Reference model: phase 0 idle, 1 loading, 2 program resident, 3 checksum error.
  int   m_phase = 0;
  bit   m_wr = 1'b0;       // current cycle is a write cycle
  int   m_idx = 0;         // word being loaded; DEPTH means checksum bits
  int   m_nbits = 0;
  logic [1:0] m_acc = 2'b00;
  logic [1:0] m_word = 2'b00;
  logic [1:0] m_xor = 2'b00;
  int   m_writes = 0;
  int   d_writes = 0;
  logic [3:0] dut_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model advances on each clock edge from the inputs it sees.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_wr = 1'b0; m_idx = 0; m_nbits = 0;
      m_acc = 2'b00; m_word = 2'b00; m_xor = 2'b00;
    end else if (m_phase != 1) begin
      if (start) begin
        m_phase = 1; m_idx = 0; m_nbits = 0; m_xor = 2'b00;
      end
    end else if (m_wr) begin
      m_wr = 1'b0;
      m_xor = m_xor ^ m_word;
      m_idx++;
      if (m_idx == DEPTH && !CSUM_ON) m_phase = 2;
    end else if (ser_valid) begin
      m_acc = {m_acc[0], ser_bit};
      m_nbits++;
      if (m_nbits == INSTR_W) begin
        m_nbits = 0;
        if (m_idx < DEPTH) begin
          m_word = m_acc; m_wr = 1'b1; m_writes++;
        end else begin
          m_phase = (m_acc == m_xor) ? 2 : 3;
        end
      end
    end
  end

  // Compare DUT outputs with the model just after every edge.
  always @(posedge clk) begin
    #1;
    chk("ser_ready", 32'(ser_ready), 32'(m_phase == 1 && !m_wr));
    chk("imem_we",   32'(imem_we),   32'(m_wr));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_phase != 2));
    chk("load_done", 32'(load_done), 32'(m_phase == 2));
    chk("load_err",  32'(load_err),  32'(m_phase == 3));
    if (m_wr) begin
      chk("imem_addr",  32'(imem_addr),  32'(m_idx));
      chk("imem_wdata", 32'(imem_wdata), 32'(m_word));
    end
    if (imem_we) begin
      dut_log.push_back({imem_addr, imem_wdata});
      d_writes++;
    end
    if (prev_cr && !cpu_reset) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0; start_cyc = cyc;
  endtask

  task automatic send_bit(input logic b, input int gmin, input int gmax, input bit rnd_start);
    int n; bit acc;
    n = 0; acc = 1'b0;
    ser_valid = 1'b0;
    repeat ($urandom_range(gmax, gmin)) step();
    ser_valid = 1'b1; ser_bit = b;
    do begin
      acc = (m_phase == 1 && !m_wr);
      if (rnd_start) start = ($urandom_range(7, 0) == 0);
      step(); n++;
    end while (!acc && n < 20);
    start = 1'b0; ser_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [1:0] w, input int gmin, input int gmax, input bit rs);
    send_bit(w[1], gmin, gmax, rs);
    send_bit(w[0], gmin, gmax, rs);
  endtask

  task automatic settle();
    int n; n = 0;
    while (m_phase == 1 && n < 12) begin step(); n++; end
    if (m_phase == 1) chk("settle_timeout", 32'd0, 32'd1);
  endtask

  // Full load of an 8-bit packed program (word 0 in the top bits).
  task automatic load(input logic [7:0] prog, input int gmin, input int gmax,
                      input bit rs, input int mid_start_word, input bit bad_csum, input bit do_st);
    logic [1:0] cs;
    if (do_st) do_start();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == mid_start_word) begin start = 1'b1; step(); start = 1'b0; end
      send_word(prog[7-2*i -: 2], gmin, gmax, rs);
    end
    cs = prog[7:6] ^ prog[5:4] ^ prog[3:2] ^ prog[1:0];
    if (bad_csum) cs = cs ^ 2'b01;
    if (CSUM_ON) send_word(cs, gmin, gmax, rs);
    settle();
  endtask

  task automatic chk_log_ref(input string tag);
    logic [3:0] exp_log [4];
    exp_log[0] = 4'b00_01; exp_log[1] = 4'b01_11; exp_log[2] = 4'b10_00; exp_log[3] = 4'b11_00;
    chk({tag, "_nwrites"}, 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_write"}, 32'((dut_log.size() > i) ? dut_log[i] : 4'hF), 32'(exp_log[i]));
  endtask

  initial begin
    logic [7:0] rp;
    int nb;
    reset_n = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0;
    repeat (3) step();
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_ser_ready", 32'(ser_ready), 32'd0);
    reset_n = 1'b1;
    // Idle with no start: nothing moves.
    ser_valid = 1'b1; ser_bit = 1'b1;
    repeat (8) step();
    ser_valid = 1'b0;
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle_writes", 32'(d_writes), 32'd0);

    // Back-to-back program 01 11 00 00.
    dut_log.delete();
    load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    chk_log_ref("b2b");
    chk("cpu_reset_fall_latency", 32'(fall_cyc - start_cyc), 32'(DEPTH*(INSTR_W+1) + CSUM_BITS));
    chk("b2b_done", 32'(load_done), 32'd1);

    // Same program with 3-cycle valid gaps.
    dut_log.delete();
    load(8'b01_11_00_00, 3, 3, 1'b0, -1, 1'b0, 1'b1);
    chk_log_ref("gap");

    // Start pulsed mid-load is ignored; start in DONE reloads from 0.
    dut_log.delete();
    load(8'b01_11_00_00, 0, 1, 1'b0, 2, 1'b0, 1'b1);
    chk_log_ref("midstart");
    do_start();
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_done", 32'(load_done), 32'd0);
    dut_log.delete();
    load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    chk_log_ref("reload");

    // Reset after word 2 is written.
    dut_log.delete();
    do_start();
    for (int i = 0; i < 3; i++) send_word(2'b10, 0, 0, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    step(); reset_n = 1'b1;
    ser_valid = 1'b1; repeat (5) step(); ser_valid = 1'b0;
    chk("midrst_nwrites", 32'(dut_log.size()), 32'd3);
    dut_log.delete();
    load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    chk_log_ref("afterrst");

`ifdef PROG_LOADER_CHECKSUM_EN
    load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b0, 1'b1);
    chk("csum_ok_done", 32'(load_done), 32'd1);
    load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b1, 1'b1);
    chk("csum_bad_err", 32'(load_err), 32'd1);
    chk("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("csum_bad_done", 32'(load_done), 32'd0);
    do_start();
    chk("csum_err_cleared", 32'(load_err), 32'd0);
    settle_after_start: begin
      load(8'b01_11_00_00, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    end
`endif

    // Randomized loads, some interrupted by reset.
    for (int k = 0; k < 25; k++) begin
      rp = 8'($urandom);
      if ($urandom_range(5, 0) == 0) begin
        do_start();
        nb = $urandom_range(2 * DEPTH - 1, 0);
        for (int j = 0; j < nb; j++) send_bit(1'($urandom), 0, 2, 1'b1);
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
      end else begin
        load(rp, 0, 2, 1'b1, -1, 1'($urandom_range(3, 0) == 0), 1'b1);
      end
    end
    repeat (3) step();
    chk("total_writes", 32'(d_writes), 32'(m_writes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
